// File: rtl/memory_stage.sv
// memory_stage: MIPS M->W pipeline stage with a ready/req data-memory handshake,
// wait-state timeout and sticky error flag for misaligned or aborted accesses.
module memory_stage #(
    parameter int width   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] ALUOutM,
    input  logic [width-1:0] WriteDataM,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic             MemWriteM,
    input  logic             err_clr,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [width-1:0] dmem_addr,
    output logic [width-1:0] dmem_wdata,
    input  logic [width-1:0] dmem_rdata,
    input  logic             dmem_ready,
    output logic             StallM,
    output logic [width-1:0] ResultW,
    output logic [4:0]       WriteRegW,
    output logic             RegWriteW,
    output logic             mem_err
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt, w_cnt_next;
    logic [width-1:0] r_alu_out_w, r_read_data_w;
    logic             r_mem_to_reg_w;
    logic             w_access, w_misaligned, w_done, w_abort, w_kill;

    assign dmem_we    = MemWriteM;
    assign dmem_addr  = ALUOutM;
    assign dmem_wdata = WriteDataM;
    assign ResultW    = r_mem_to_reg_w ? r_read_data_w : r_alu_out_w;

    // Outputs are gated by rst_n so a reset mid-access drops the request at once.
    always_comb begin
        w_access     = MemtoRegM | MemWriteM;
        w_misaligned = (r_state == IDLE) & w_access & (ALUOutM[1:0] != 2'b00);
        dmem_req     = rst_n & ((r_state == WAIT) | (w_access & ~w_misaligned));
        w_done       = dmem_req & dmem_ready;
        w_abort      = dmem_req & (r_state == WAIT) & ~dmem_ready & (r_cnt == CW'(TIMEOUT));
        StallM       = dmem_req & ~w_done & ~w_abort;
        w_kill       = w_misaligned | w_abort;
        w_next       = StallM ? WAIT : IDLE;
        w_cnt_next   = StallM ? r_cnt + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // A stalled cycle inserts a bubble: only the write enable changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_out_w    <= '0;
            r_read_data_w  <= '0;
            r_mem_to_reg_w <= 1'b0;
            WriteRegW      <= '0;
            RegWriteW      <= 1'b0;
            mem_err        <= 1'b0;
        end else begin
            if (w_kill)
                mem_err <= 1'b1;
            else if (err_clr)
                mem_err <= 1'b0;
            if (StallM) begin
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW      <= RegWriteM & ~w_kill;
                WriteRegW      <= WriteRegM;
                r_alu_out_w    <= ALUOutM;
                r_mem_to_reg_w <= MemtoRegM;
                if (w_done)
                    r_read_data_w <= dmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: table-driven and randomized checks of memory_stage against a
// transaction-level model of stall length, request length, W results and mem_err.
module tb_memory_stage;
    localparam int T = 15;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] ALUOutM = '0, WriteDataM = '0, dmem_rdata = '0;
    logic [4:0]  WriteRegM = '0;
    logic        RegWriteM = 1'b0, MemtoRegM = 1'b0, MemWriteM = 1'b0, err_clr = 1'b0, dmem_ready = 1'b0;
    logic        dmem_req, dmem_we, StallM, RegWriteW, mem_err;
    logic [31:0] dmem_addr, dmem_wdata, ResultW;
    logic [4:0]  WriteRegW;

    int n_chk = 0, n_pass = 0;

    memory_stage #(.width(32), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .MemWriteM(MemWriteM), .err_clr(err_clr), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ready(dmem_ready), .StallM(StallM), .ResultW(ResultW), .WriteRegW(WriteRegW),
        .RegWriteW(RegWriteW), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // op: 0 = ALU, 1 = load, 2 = store; k = cycle index (from issue) where ready is driven.
    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr, wdata;
        logic [4:0]  wreg;
        logic        regw;
        int          k;
        logic [31:0] rdata;
        logic        clr;
        int          e_stall, e_req;
        logic [31:0] e_res;
        logic        chk_res, e_regw, e_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: an aligned access stalls min(k,T) cycles and completes only if k<=T.
    function automatic void model(inout vec_t v, inout logic err);
        logic acc, go, ok;
        int   w;
        acc = v.op != 2'd0;
        go  = acc && (v.addr[1:0] == 2'b00);
        ok  = !acc || (go && v.k <= T);
        w   = (v.k < T) ? v.k : T;
        v.e_stall = go ? w : 0;
        v.e_req   = go ? w + 1 : 0;
        v.e_regw  = v.regw & ok;
        v.chk_res = ok || (v.op != 2'd1);
        v.e_res   = (v.op == 2'd1) ? v.rdata : v.addr;
        err       = !ok ? 1'b1 : (v.clr ? 1'b0 : err);
        v.e_err   = err;
    endfunction

    task automatic run_and_check(input vec_t v);
        int   ns, nr;
        logic done, bus_ok;
        ALUOutM    = v.addr;
        WriteDataM = v.wdata;
        WriteRegM  = v.wreg;
        RegWriteM  = v.regw;
        MemtoRegM  = (v.op == 2'd1);
        MemWriteM  = (v.op == 2'd2);
        dmem_rdata = v.rdata;
        err_clr    = 1'b0;
        ns = 0; nr = 0; done = 1'b0; bus_ok = 1'b1;
        for (int c = 0; c < T + 5 && !done; c++) begin
            dmem_ready = (c == v.k);
            @(negedge clk);
            if (dmem_req) begin
                nr++;
                if (dmem_addr !== v.addr || dmem_wdata !== v.wdata || dmem_we !== (v.op == 2'd2))
                    bus_ok = 1'b0;
            end
            if (StallM) begin
                ns++;
                if (c > 0) chk("stall_bubble", {31'b0, RegWriteW}, 32'd0);
            end else begin
                done    = 1'b1;
                err_clr = v.clr;
            end
            @(posedge clk);
            #1;
        end
        dmem_ready = 1'b0;
        err_clr    = 1'b0;
        chk("txn_bound", {31'b0, done}, 32'd1);
        chk("stall_cycles", ns, v.e_stall);
        chk("req_cycles", nr, v.e_req);
        chk("RegWriteW", {31'b0, RegWriteW}, {31'b0, v.e_regw});
        chk("WriteRegW", {27'b0, WriteRegW}, {27'b0, v.wreg});
        chk("mem_err", {31'b0, mem_err}, {31'b0, v.e_err});
        if (v.chk_res) chk("ResultW", ResultW, v.e_res);
        if (nr > 0) chk("bus_stable", {31'b0, bus_ok}, 32'd1);
    endtask

    initial begin
        vec_t tbl[10];
        vec_t v;
        logic m_err;
        tbl[0] = '{2'd0, 32'h1234, 32'h0, 5'd5, 1'b1, 0, 32'h0, 1'b0, 0, 0, 32'h1234, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{2'd1, 32'h40, 32'h0, 5'd7, 1'b1, 0, 32'hDEADBEEF, 1'b0, 0, 1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{2'd2, 32'h80, 32'h55, 5'd0, 1'b0, 3, 32'h0, 1'b0, 3, 4, 32'h80, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{2'd1, 32'h100, 32'h0, 5'd9, 1'b1, 99, 32'h1111, 1'b0, 15, 16, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[4] = '{2'd0, 32'h8, 32'h0, 5'd3, 1'b1, 0, 32'h0, 1'b1, 0, 0, 32'h8, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{2'd1, 32'h42, 32'h0, 5'd4, 1'b1, 0, 32'h2222, 1'b1, 0, 0, 32'h0, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{2'd0, 32'hC, 32'h0, 5'd6, 1'b1, 5, 32'h0, 1'b1, 0, 0, 32'hC, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{2'd1, 32'h200, 32'h0, 5'd10, 1'b1, 15, 32'hCAFEF00D, 1'b0, 15, 16, 32'hCAFEF00D, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{2'd2, 32'h204, 32'h77, 5'd0, 1'b1, 14, 32'h0, 1'b0, 14, 15, 32'h204, 1'b1, 1'b1, 1'b0};
        tbl[9] = '{2'd2, 32'h206, 32'h1, 5'd2, 1'b0, 0, 32'h0, 1'b0, 0, 0, 32'h206, 1'b1, 1'b0, 1'b1};

        // Reset with an aligned load presented: no request or stall may escape.
        ALUOutM = 32'h40; MemtoRegM = 1'b1;
        #1;
        chk("rst_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_stall", {31'b0, StallM}, 32'd0);
        chk("rst_ResultW", ResultW, 32'd0);
        chk("rst_WriteRegW", {27'b0, WriteRegW}, 32'd0);
        chk("rst_RegWriteW", {31'b0, RegWriteW}, 32'd0);
        chk("rst_mem_err", {31'b0, mem_err}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) run_and_check(tbl[i]);

        // Reset asserted in the second WAIT cycle of a stalled load.
        ALUOutM = 32'h300; MemtoRegM = 1'b1; MemWriteM = 1'b0; RegWriteM = 1'b1; dmem_ready = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("wait_req", {31'b0, dmem_req}, 32'd1);
        chk("wait_stall", {31'b0, StallM}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("wrst_req", {31'b0, dmem_req}, 32'd0);
        chk("wrst_stall", {31'b0, StallM}, 32'd0);
        chk("wrst_ResultW", ResultW, 32'd0);
        chk("wrst_WriteRegW", {27'b0, WriteRegW}, 32'd0);
        chk("wrst_RegWriteW", {31'b0, RegWriteW}, 32'd0);
        chk("wrst_mem_err", {31'b0, mem_err}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_err = 1'b0;

        // An ALU op right after release must not see a leftover WAIT request.
        v = '{2'd0, 32'h3C, 32'h0, 5'd11, 1'b1, 0, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, 1'b0, 1'b0};
        model(v, m_err);
        run_and_check(v);

        for (int n = 0; n < 120; n++) begin
            v.op    = 2'($urandom_range(0, 2));
            v.addr  = $urandom;
            if ($urandom_range(0, 2) != 0) v.addr[1:0] = 2'b00;
            v.wdata = $urandom;
            v.wreg  = 5'($urandom);
            v.regw  = 1'($urandom);
            v.k     = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, T + 2));
            v.rdata = $urandom;
            v.clr   = ($urandom_range(0, 3) == 0);
            model(v, m_err);
            run_and_check(v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
